morse_char_queue: RTL and testbench

Character buffer and sequencer between the UART receiver and the morse generator. It filters and case-folds received ASCII bytes and stores them in a FIFO. It then issues them one at a time to the morse generator, waiting for each character's done pulse before starting the next. It replaces the direct "UART tx done starts morse" coupling, so bursts typed faster than morse playback are not lost.

---
 rtl/morse_char_queue.sv | 241 ++++++++++++++++++++++++
 tb/tb_morse_char_queue.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_queue.sv
// ---------------------------------------------------------------------------
// morse_char_queue
//
// Character buffer and sequencer that sits between the UART receiver and the
// morse generator. Received bytes are filtered (space, digits and letters
// only), lowercase letters are folded to uppercase, and the survivors are
// stored in a FIFO. A small FSM then hands the characters to the morse
// generator one at a time, waiting for each character's done pulse (or a
// timeout) before starting the next, so typing bursts are never lost while
// morse playback is slower than the UART.
//
// Parameters
//   FIFO_ADDR_BITS  log2 of the FIFO depth (default 6 -> 64 entries)
//   TIMEOUT_CYCLES  max cycles to wait for morse_done_i, 0 disables the wait
//                   limit (default 100_000_000, one second at 100 MHz)
//
// Ports
//   clk_i         system clock
//   reset_ni      asynchronous active-low reset
//   rx_data_i     received byte, valid while rx_valid_i is high
//   rx_valid_i    one-cycle strobe from the UART receiver
//   morse_done_i  one-cycle pulse from the morse generator, character done
//   ascii_o       character presented to the morse generator
//   morse_en_o    one-cycle start pulse to the morse generator
//   fifo_count_o  number of stored entries (one bit wider than the pointers)
//   empty_o       FIFO holds no entries
//   full_o        FIFO holds 2^FIFO_ADDR_BITS entries
//   busy_o        sequencer is fetching, issuing or waiting on a character
//   overflow_o    sticky, an accepted byte was dropped because of full_o
//   timeout_o     sticky, a done wait expired
//   reject_cnt_o  saturating count of bytes removed by the filter
// ---------------------------------------------------------------------------
module morse_char_queue #(
   parameter int unsigned FIFO_ADDR_BITS = 6,
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
   input  logic                      clk_i,
   input  logic                      reset_ni,
   input  logic [7:0]                rx_data_i,
   input  logic                      rx_valid_i,
   input  logic                      morse_done_i,
   output logic [7:0]                ascii_o,
   output logic                      morse_en_o,
   output logic [FIFO_ADDR_BITS:0]   fifo_count_o,
   output logic                      empty_o,
   output logic                      full_o,
   output logic                      busy_o,
   output logic                      overflow_o,
   output logic                      timeout_o,
   output logic [7:0]                reject_cnt_o
);

   localparam int unsigned DEPTH = 1 << FIFO_ADDR_BITS;
   localparam int unsigned CNT_W = FIFO_ADDR_BITS + 1;
   localparam int unsigned TMR_W = 27;

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   // The timer starts at zero in the first WAIT cycle, so the wait expires
   // when it has counted TIMEOUT_CYCLES-1; the flag and the return to IDLE
   // then become visible exactly TIMEOUT_CYCLES cycles after WAIT entry.
   localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TMR_W-1:0] TMR_LAST   =
      (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] REJECT_MAX = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   state_t                    state;
   state_t                    state_next;

   logic                      byte_ok;
   logic [7:0]                byte_fold;

   logic                      do_push;
   logic                      do_pop;
   logic                      do_drop;
   logic                      do_reject;

   logic [FIFO_ADDR_BITS-1:0] wr_ptr;
   logic [FIFO_ADDR_BITS-1:0] rd_ptr;
   logic [CNT_W-1:0]          count_next;

   logic [7:0]                mem [DEPTH];
   logic [7:0]                rd_data;

   logic [TMR_W-1:0]          wait_timer;
   logic                      wait_expired;

   // Accept filter: space, 0-9, A-Z pass unchanged; a-z pass with 0x20
   // removed so the morse generator only ever sees uppercase.
   always_comb begin
      byte_ok   = 1'b0;
      byte_fold = rx_data_i;
      if (rx_data_i == 8'h20) begin
         byte_ok = 1'b1;
      end else if ((rx_data_i >= 8'h30) && (rx_data_i <= 8'h39)) begin
         byte_ok = 1'b1;
      end else if ((rx_data_i >= 8'h41) && (rx_data_i <= 8'h5A)) begin
         byte_ok = 1'b1;
      end else if ((rx_data_i >= 8'h61) && (rx_data_i <= 8'h7A)) begin
         byte_ok   = 1'b1;
         byte_fold = rx_data_i - 8'h20;
      end
   end

   // Full is judged on the registered count, so a byte arriving in the same
   // cycle as a pop from a full FIFO is still dropped.
   assign do_push   = rx_valid_i &&  byte_ok && !full_o;
   assign do_drop   = rx_valid_i &&  byte_ok &&  full_o;
   assign do_reject = rx_valid_i && !byte_ok;
   assign do_pop    = (state == ST_IDLE) && !empty_o;

   always_comb begin
      count_next = fifo_count_o;
      if (do_push && !do_pop) begin
         count_next = fifo_count_o + CNT_ONE;
      end else if (!do_push && do_pop) begin
         count_next = fifo_count_o - CNT_ONE;
      end
   end

   // Storage has no reset: emptiness is defined by the pointers and count.
   // The read port is registered and captured on the pop edge, before the
   // read pointer has moved on.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr] <= byte_fold;
      end
      if (do_pop) begin
         rd_data <= mem[rd_ptr];
      end
   end

   // Pointers wrap naturally at the FIFO depth; flags are registered from
   // the next count so they always agree with fifo_count_o.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count_o <= '0;
         empty_o      <= 1'b1;
         full_o       <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fifo_count_o <= count_next;
         empty_o      <= (count_next == CNT_ZERO);
         full_o       <= (count_next == CNT_FULL);
      end
   end

   // Sequencer next state. Done is only honoured in WAIT, which also means a
   // done pulse coinciding with ISSUE is ignored. Done wins over an expiring
   // timer in the same cycle.
   always_comb begin
      state_next   = state;
      wait_expired = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!empty_o) begin
               state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (morse_done_i) begin
               state_next = ST_IDLE;
            end else if (TIMEOUT_EN && (wait_timer == TMR_LAST)) begin
               wait_expired = 1'b1;
               state_next   = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State register and the registered sequencer outputs. The start pulse
   // and busy flag are decoded from the next state so they line up with the
   // state they describe. ascii_o only changes on the edge into ISSUE.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state      <= ST_IDLE;
         busy_o     <= 1'b0;
         morse_en_o <= 1'b0;
         ascii_o    <= 8'h00;
         wait_timer <= '0;
      end else begin
         state      <= state_next;
         busy_o     <= (state_next != ST_IDLE);
         morse_en_o <= (state_next == ST_ISSUE);
         if (state == ST_FETCH) begin
            ascii_o <= rd_data;
         end
         if (state == ST_WAIT) begin
            wait_timer <= wait_timer + {{(TMR_W-1){1'b0}}, 1'b1};
         end else begin
            wait_timer <= '0;
         end
      end
   end

   // Sticky error flags and the saturating reject counter.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         overflow_o   <= 1'b0;
         timeout_o    <= 1'b0;
         reject_cnt_o <= 8'h00;
      end else begin
         if (do_drop) begin
            overflow_o <= 1'b1;
         end
         if (wait_expired) begin
            timeout_o <= 1'b1;
         end
         if (do_reject && (reject_cnt_o != REJECT_MAX)) begin
            reject_cnt_o <= reject_cnt_o + 8'h01;
         end
      end
   end

endmodule

// File: tb/tb_morse_char_queue.sv
// ---------------------------------------------------------------------------
// tb_morse_char_queue
//
// Directed and randomized bench for morse_char_queue. The reference model is
// a queue of the characters that should reach the morse generator, built
// from the character rules (accepted ranges, lowercase folding) plus a
// saturating reject tally. A second instance with a short timeout shares the
// stimulus and is only watched during the timeout scenario.
// ---------------------------------------------------------------------------
module tb_morse_char_queue;

   logic       clk;
   logic       reset_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       morse_done;

   logic [7:0] ascii;
   logic       morse_en;
   logic [6:0] fifo_count;
   logic       empty;
   logic       full;
   logic       busy;
   logic       overflow;
   logic       timeout;
   logic [7:0] reject_cnt;

   logic [7:0] to_ascii;
   logic       to_morse_en;
   logic [6:0] to_fifo_count;
   logic       to_empty;
   logic       to_full;
   logic       to_busy;
   logic       to_overflow;
   logic       to_timeout;
   logic [7:0] to_reject_cnt;

   int         n_checks;
   int         n_fail;
   int         cyc;
   logic [7:0] exp_q[$];
   int         exp_rej;
   bit         auto_done;
   bit         gap_check;
   bit         watch_to;
   bit         done_pending;
   int         done_at;
   int         done_min;
   int         done_max;
   int         last_done_cyc;
   int         en_seen;
   int         en_base;
   int         c0;
   string      word;
   logic [7:0] rnd_byte;

   morse_char_queue dut (
      .clk_i        (clk),
      .reset_ni     (reset_n),
      .rx_data_i    (rx_data),
      .rx_valid_i   (rx_valid),
      .morse_done_i (morse_done),
      .ascii_o      (ascii),
      .morse_en_o   (morse_en),
      .fifo_count_o (fifo_count),
      .empty_o      (empty),
      .full_o       (full),
      .busy_o       (busy),
      .overflow_o   (overflow),
      .timeout_o    (timeout),
      .reject_cnt_o (reject_cnt)
   );

   morse_char_queue #(.TIMEOUT_CYCLES(50)) dut_to (
      .clk_i        (clk),
      .reset_ni     (reset_n),
      .rx_data_i    (rx_data),
      .rx_valid_i   (rx_valid),
      .morse_done_i (morse_done),
      .ascii_o      (to_ascii),
      .morse_en_o   (to_morse_en),
      .fifo_count_o (to_fifo_count),
      .empty_o      (to_empty),
      .full_o       (to_full),
      .busy_o       (to_busy),
      .overflow_o   (to_overflow),
      .timeout_o    (to_timeout),
      .reject_cnt_o (to_reject_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Character rules: returns the stored value, or -1 for a filtered byte.
   function automatic int fold(input logic [7:0] b);
      if (b == 8'h20)                   return 32;
      if (b >= 8'h30 && b <= 8'h39)     return int'(b);
      if (b >= 8'h41 && b <= 8'h5A)     return int'(b);
      if (b >= 8'h61 && b <= 8'h7A)     return int'(b) - 32;
      return -1;
   endfunction

   function automatic logic [7:0] rand_accepted();
      int k;
      k = int'($urandom_range(62, 0));
      if (k == 0)  return 8'h20;
      if (k <= 10) return 8'(8'h30 + k - 1);
      if (k <= 36) return 8'(8'h41 + k - 11);
      return 8'(8'h61 + k - 37);
   endfunction

   function automatic logic [7:0] rand_rejected();
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < 1000; i++) begin
         b = 8'($urandom_range(255, 0));
         if (fold(b) < 0) break;
      end
      return b;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)",
                tag, observed, expected, cyc);
      end
   endtask

   // One clock cycle: outputs are sampled 1 time unit after the edge, every
   // issued character is compared against the model queue, and the done
   // responder drives morse_done for the cycle it was scheduled in.
   task automatic tick();
      logic       en_now;
      logic [7:0] chr_now;
      logic [7:0] exp_chr;
      @(posedge clk);
      #1;
      cyc++;
      en_now  = watch_to ? to_morse_en : morse_en;
      chr_now = watch_to ? to_ascii    : ascii;
      if (en_now === 1'b1) begin
         en_seen++;
         if (exp_q.size() == 0) begin
            check_output("unexpected_issue", 32'(chr_now), 32'hFFFF_FFFF);
         end else begin
            exp_chr = exp_q.pop_front();
            check_output("issue_char", 32'(chr_now), 32'(exp_chr));
         end
         if (gap_check && last_done_cyc >= 0) begin
            check_output("done_to_en_gap", 32'(cyc - last_done_cyc), 32'd3);
         end
         last_done_cyc = -1;
         if (auto_done) begin
            done_pending = 1'b1;
            done_at      = cyc + int'($urandom_range(done_max, done_min));
         end
      end
      rx_valid   = 1'b0;
      morse_done = 1'b0;
      if (done_pending && cyc == done_at) begin
         morse_done    = 1'b1;
         done_pending  = 1'b0;
         last_done_cyc = cyc;
      end
   endtask

   // Drive one received byte in the current cycle and update the model.
   // 'storable' is cleared by the caller when the FIFO is known to be full.
   task automatic apply_stimulus(input logic [7:0] b, input bit storable);
      int f;
      f        = fold(b);
      rx_data  = b;
      rx_valid = 1'b1;
      if (f < 0) begin
         if (exp_rej < 255) exp_rej++;
      end else if (storable) begin
         exp_q.push_back(8'(f));
      end
      tick();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || done_pending) && n < budget) begin
         tick();
         n++;
      end
      check_output("drain_in_budget", 32'(exp_q.size() + int'(done_pending)), 32'd0);
      repeat (2) tick();
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_ascii"},      32'(ascii),      32'h00);
      check_output({tag, "_morse_en"},   32'(morse_en),   32'd0);
      check_output({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
      check_output({tag, "_empty"},      32'(empty),      32'd1);
      check_output({tag, "_full"},       32'(full),       32'd0);
      check_output({tag, "_busy"},       32'(busy),       32'd0);
      check_output({tag, "_overflow"},   32'(overflow),   32'd0);
      check_output({tag, "_timeout"},    32'(timeout),    32'd0);
      check_output({tag, "_reject_cnt"}, 32'(reject_cnt), 32'd0);
   endtask

   task automatic do_reset();
      #3 reset_n = 1'b0;
      tick();
      tick();
      exp_q.delete();
      exp_rej       = 0;
      done_pending  = 1'b0;
      last_done_cyc = -1;
      #3 reset_n = 1'b1;
      tick();
   endtask

   initial begin
      reset_n       = 1'b0;
      rx_data       = 8'h00;
      rx_valid      = 1'b0;
      morse_done    = 1'b0;
      n_checks      = 0;
      n_fail        = 0;
      cyc           = 0;
      exp_rej       = 0;
      auto_done     = 1'b0;
      gap_check     = 1'b0;
      watch_to      = 1'b0;
      done_pending  = 1'b0;
      done_at       = 0;
      done_min      = 1;
      done_max      = 1;
      last_done_cyc = -1;
      en_seen       = 0;

      // Power-on reset values.
      tick();
      tick();
      check_reset_values("por");
      #3 reset_n = 1'b1;
      tick();

      // Single lowercase character: 3-cycle latency, folded to 'A'.
      $display("[TB] single character");
      apply_stimulus(8'h61, 1'b1);
      check_output("single_count_c1", 32'(fifo_count), 32'd1);
      check_output("single_empty_c1", 32'(empty),      32'd0);
      check_output("single_en_c1",    32'(morse_en),   32'd0);
      tick();
      check_output("single_count_c2", 32'(fifo_count), 32'd0);
      check_output("single_busy_c2",  32'(busy),       32'd1);
      check_output("single_en_c2",    32'(morse_en),   32'd0);
      tick();
      check_output("single_en_c3",    32'(morse_en),   32'd1);
      check_output("single_ascii_c3", 32'(ascii),      32'h41);
      tick();
      check_output("single_en_c4",    32'(morse_en),   32'd0);
      repeat (3) tick();
      check_output("single_busy_wait", 32'(busy),      32'd1);
      morse_done = 1'b1;
      tick();
      check_output("single_busy_after_done", 32'(busy), 32'd0);
      check_output("single_reject",   32'(reject_cnt), 32'd0);
      check_output("single_ascii_hold", 32'(ascii),    32'h41);

      // Ordering, folding and filtering, with done 10 cycles after each start.
      $display("[TB] ordering and filter");
      auto_done     = 1'b1;
      done_min      = 10;
      done_max      = 10;
      gap_check     = 1'b1;
      last_done_cyc = -1;
      word          = "hI 7!";
      for (int i = 0; i < word.len(); i++) begin
         apply_stimulus(word[i], 1'b1);
      end
      drain(300);
      gap_check = 1'b0;
      check_output("order_reject", 32'(reject_cnt), 32'(exp_rej));

      // Fill to full while the first character waits, then drop one.
      $display("[TB] full and overflow");
      auto_done = 1'b0;
      for (int i = 0; i < 65; i++) begin
         apply_stimulus(rand_accepted(), 1'b1);
      end
      check_output("fill_count",    32'(fifo_count), 32'd64);
      check_output("fill_full",     32'(full),       32'd1);
      check_output("fill_overflow", 32'(overflow),   32'd0);
      apply_stimulus(rand_accepted(), 1'b0);
      check_output("drop_count",    32'(fifo_count), 32'd64);
      check_output("drop_full",     32'(full),       32'd1);
      check_output("drop_overflow", 32'(overflow),   32'd1);
      auto_done = 1'b1;
      done_min  = 1;
      done_max  = 4;
      morse_done = 1'b1;
      tick();
      drain(2000);
      check_output("drain_empty", 32'(empty),      32'd1);
      check_output("drain_count", 32'(fifo_count), 32'd0);
      check_output("drain_full",  32'(full),       32'd0);

      // Push arriving in the very cycle the FSM pops from a full FIFO.
      $display("[TB] push and pop at full");
      do_reset();
      auto_done = 1'b0;
      for (int i = 0; i < 65; i++) begin
         apply_stimulus(rand_accepted(), 1'b1);
      end
      check_output("pp_count_full", 32'(fifo_count), 32'd64);
      morse_done = 1'b1;
      tick();
      check_output("pp_idle_busy",  32'(busy),       32'd0);
      check_output("pp_idle_full",  32'(full),       32'd1);
      apply_stimulus(rand_accepted(), 1'b0);
      check_output("pp_count",      32'(fifo_count), 32'd63);
      check_output("pp_overflow",   32'(overflow),   32'd1);
      check_output("pp_full",       32'(full),       32'd0);
      auto_done = 1'b1;
      drain(2000);
      check_output("pp_drain_empty", 32'(empty), 32'd1);

      // Timeout on the short-timeout instance; the next byte still issues.
      $display("[TB] timeout");
      do_reset();
      auto_done = 1'b0;
      watch_to  = 1'b1;
      c0 = cyc;
      apply_stimulus(8'h45, 1'b1);
      apply_stimulus(8'h54, 1'b1);
      while (cyc < c0 + 53) tick();
      check_output("to_before", 32'(to_timeout), 32'd0);
      tick();
      check_output("to_rise",   32'(to_timeout), 32'd1);
      check_output("to_idle",   32'(to_busy),    32'd0);
      tick();
      tick();
      check_output("to_next_en",    32'(to_morse_en), 32'd1);
      check_output("to_next_ascii", 32'(to_ascii),    32'h54);
      check_output("to_main_clear", 32'(timeout),     32'd0);
      morse_done = 1'b1;
      tick();
      check_output("to_q_done", 32'(exp_q.size()), 32'd0);
      watch_to = 1'b0;
      do_reset();

      // Asynchronous reset while a character is in flight.
      $display("[TB] reset mid-operation");
      auto_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(rand_accepted(), 1'b1);
      end
      check_output("mid_count_before", 32'(fifo_count), 32'd5);
      check_output("mid_busy_before",  32'(busy),       32'd1);
      tick();
      #3 reset_n = 1'b0;
      #1;
      check_reset_values("mid");
      exp_q.delete();
      exp_rej = 0;
      tick();
      #3 reset_n = 1'b1;
      en_base = en_seen;
      repeat (10) tick();
      check_output("mid_no_en", 32'(en_seen - en_base), 32'd0);
      c0 = cyc;
      apply_stimulus(8'h37, 1'b1);
      tick();
      check_output("mid_new_en_c2", 32'(morse_en), 32'd0);
      tick();
      check_output("mid_new_en_c3", 32'(morse_en), 32'd1);
      check_output("mid_new_ascii", 32'(ascii),    32'h37);
      morse_done = 1'b1;
      tick();

      // Randomized traffic against the model, then reject saturation.
      $display("[TB] random traffic");
      do_reset();
      auto_done = 1'b1;
      done_min  = 1;
      done_max  = 6;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(3, 0)) tick();
         if ($urandom_range(1, 0) == 1) rnd_byte = rand_accepted();
         else                           rnd_byte = 8'($urandom_range(255, 0));
         apply_stimulus(rnd_byte, 1'b1);
      end
      drain(2000);
      check_output("rand_reject",   32'(reject_cnt), 32'(exp_rej));
      check_output("rand_overflow", 32'(overflow),   32'd0);
      check_output("rand_empty",    32'(empty),      32'd1);
      check_output("rand_count",    32'(fifo_count), 32'd0);
      check_output("rand_timeout",  32'(timeout),    32'd0);
      for (int i = 0; i < 300; i++) begin
         apply_stimulus(rand_rejected(), 1'b1);
      end
      tick();
      check_output("reject_saturate", 32'(reject_cnt), 32'(exp_rej));
      check_output("reject_no_issue", 32'(busy),       32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
